// File: rtl/de_ex_pipe_reg.sv
// DE->EX pipeline register with load-use hazard detection, bubble insertion
// on load-use or branch flush, and saturating stall/flush counters.
module de_ex_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int ALU_FUN_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 DE_VALID,
  input  logic [XLEN-1:0]      DE_PC,
  input  logic [4:0]           DE_RS1_ADDR,
  input  logic [4:0]           DE_RS2_ADDR,
  input  logic [4:0]           DE_RD_ADDR,
  input  logic                 DE_RS1_USED,
  input  logic                 DE_RS2_USED,
  input  logic                 DE_REG_WRITE,
  input  logic                 DE_MEM_READ,
  input  logic                 DE_MEM_WRITE,
  input  logic [ALU_FUN_W-1:0] DE_ALU_FUN,
  input  logic [XLEN-1:0]      DE_RS1_DATA,
  input  logic [XLEN-1:0]      DE_RS2_DATA,
  input  logic [XLEN-1:0]      DE_IMM,
  input  logic                 BRANCH_FLUSH,
  output logic                 DE_STALL,
  output logic                 DE_EX_VALID,
  output logic [XLEN-1:0]      DE_EX_PC,
  output logic [4:0]           DE_EX_RS1_ADDR,
  output logic [4:0]           DE_EX_RS2_ADDR,
  output logic [4:0]           DE_EX_RD_ADDR,
  output logic                 DE_EX_RS1_USED,
  output logic                 DE_EX_RS2_USED,
  output logic                 DE_EX_REG_WRITE,
  output logic                 DE_EX_MEM_READ,
  output logic                 DE_EX_MEM_WRITE,
  output logic [ALU_FUN_W-1:0] DE_EX_ALU_FUN,
  output logic [XLEN-1:0]      DE_EX_RS1_DATA,
  output logic [XLEN-1:0]      DE_EX_RS2_DATA,
  output logic [XLEN-1:0]      DE_EX_IMM,
  output logic [CNT_W-1:0]     STALL_CNT,
  output logic [CNT_W-1:0]     FLUSH_CNT
);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic [ALU_FUN_W-1:0] alu_fun;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
  } ex_t;

  ex_t de_in, ex_d, ex_q;
  logic load_use;

  assign de_in = '{valid: DE_VALID, pc: DE_PC, rs1_addr: DE_RS1_ADDR,
                   rs2_addr: DE_RS2_ADDR, rd_addr: DE_RD_ADDR,
                   rs1_used: DE_RS1_USED, rs2_used: DE_RS2_USED,
                   reg_write: DE_REG_WRITE, mem_read: DE_MEM_READ,
                   mem_write: DE_MEM_WRITE, alu_fun: DE_ALU_FUN,
                   rs1_data: DE_RS1_DATA, rs2_data: DE_RS2_DATA, imm: DE_IMM};

  // Only a load in EX with a real rd can starve a consumer; ALU results forward.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != 5'd0) & DE_VALID &
                    (((ex_q.rd_addr == DE_RS1_ADDR) & DE_RS1_USED) |
                     ((ex_q.rd_addr == DE_RS2_ADDR) & DE_RS2_USED));

  assign DE_STALL = load_use & ~BRANCH_FLUSH;

  // An invalid slot keeps its payload but must look like a bubble to forwarding.
  always_comb begin
    ex_d = de_in;
    if (!DE_VALID) begin
      ex_d.rs1_addr  = '0;
      ex_d.rs2_addr  = '0;
      ex_d.rd_addr   = '0;
      ex_d.rs1_used  = 1'b0;
      ex_d.rs2_used  = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ex_q      <= '0;
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else if (BRANCH_FLUSH) begin
      ex_q <= '0;
      if (FLUSH_CNT != {CNT_W{1'b1}}) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
    end else if (load_use) begin
      ex_q <= '0;
      if (STALL_CNT != {CNT_W{1'b1}}) STALL_CNT <= STALL_CNT + CNT_W'(1);
    end else begin
      ex_q <= ex_d;
    end
  end

  assign DE_EX_VALID     = ex_q.valid;
  assign DE_EX_PC        = ex_q.pc;
  assign DE_EX_RS1_ADDR  = ex_q.rs1_addr;
  assign DE_EX_RS2_ADDR  = ex_q.rs2_addr;
  assign DE_EX_RD_ADDR   = ex_q.rd_addr;
  assign DE_EX_RS1_USED  = ex_q.rs1_used;
  assign DE_EX_RS2_USED  = ex_q.rs2_used;
  assign DE_EX_REG_WRITE = ex_q.reg_write;
  assign DE_EX_MEM_READ  = ex_q.mem_read;
  assign DE_EX_MEM_WRITE = ex_q.mem_write;
  assign DE_EX_ALU_FUN   = ex_q.alu_fun;
  assign DE_EX_RS1_DATA  = ex_q.rs1_data;
  assign DE_EX_RS2_DATA  = ex_q.rs2_data;
  assign DE_EX_IMM       = ex_q.imm;

endmodule
